// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - Bin, one bit per clock, LSB first.
// Optional signed-overflow output Ovf enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             bit_d, borrow_nx;

  // Full-subtractor cell on the current LSBs
  always_comb begin
    bit_d     = sa_q[0] ^ sb_q[0] ^ borrow_q;
    borrow_nx = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sd_d     = sd_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          sa_d     = A;
          sb_d     = B;
          borrow_d = Bin;
          sd_d     = '0;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = A[WIDTH-1];
          b_msb_d  = B[WIDTH-1];
`endif
        end
      end
      StRun: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        sd_d     = {bit_d, sd_q[WIDTH-1:1]};
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          d_d     = {bit_d, sd_q[WIDTH-1:1]};
          bout_d  = borrow_nx;
`ifdef SERIAL_SUB_OVF_EN
          // bit_d is the result MSB on the final bit
          ovf_d   = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sd_q     <= sd_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign D    = d_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner cases,
// and randomized operands against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] d;
  logic         ovf_w;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  assign ovf_w = ovf;
`else
  assign ovf_w = 1'b0;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .Bin   (bin),
    .busy  (busy),
    .done  (done),
    .D     (d),
    .Bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } res_t;

  // Reference: plain unsigned arithmetic modulo 2^W
  function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    res_t        r;
    int unsigned ua, ub, ubin;
    logic [31:0] diff;
    ua     = ia;
    ub     = ib;
    ubin   = ibin;
    diff   = ua - ub - ubin;
    r.d    = diff[W-1:0];
    r.bout = (ua < ub + ubin);
    r.ovf  = (ia[W-1] != ib[W-1]) && (r.d[W-1] != ia[W-1]);
    return r;
  endfunction

  // One full operation from an idle DUT; returns results and observed timing
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        output res_t r, output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    r.d = d; r.bout = bout; r.ovf = ovf_w;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         bin;
    logic [W-1:0] ed;
    logic         ebout, eovf;
  } vec_t;

  vec_t vecs[9];
  res_t r, m;
  int   lat, bcnt, npulse, first, changes, offdone;
  int   pidx[$];
  logic [W-1:0] prev, dv;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h09, 8'h09, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_bout", 32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, r, lat, bcnt);
      chk($sformatf("vec%0d_d", i), 32'(r.d), 32'(vecs[i].ed));
      chk($sformatf("vec%0d_bout", i), 32'(r.bout), 32'(vecs[i].ebout));
      chk($sformatf("vec%0d_latency", i), 32'(lat), W);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), W + 1);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 32'(r.ovf), 32'(vecs[i].eovf));
`endif
    end
    chk("idle_after_op", 32'(busy), 0);

    // Start re-pulsed with new operands during RUN must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; npulse = 0; first = -1; dv = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      if (i == 5) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (first < 0) begin first = i; dv = d; end
      end
    end
    chk("ign_pulses", 32'(npulse), 1);
    chk("ign_latency", 32'(first), W);
    chk("ign_d", 32'(dv), 32'h0F);

    // Start held high: back-to-back operations every W+2 edges
    prev = d; changes = 0; offdone = 0;
    @(negedge clk);
    a = 8'h20; b = 8'h08; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (d !== prev) begin
        changes++;
        if (!done) offdone++;
        prev = d;
      end
      if (done) begin
        pidx.push_back(i);
        chk($sformatf("held_d_at_%0d", i), 32'(d), 32'h18);
      end
    end
    start = 1'b0;
    chk("held_pulses", 32'(pidx.size()), 3);
    if (pidx.size() == 3) begin
      chk("held_first", 32'(pidx[0]), W);
      chk("held_gap1", 32'(pidx[1] - pidx[0]), W + 2);
      chk("held_gap2", 32'(pidx[2] - pidx[1]), W + 2);
    end
    chk("held_d_changes", 32'(changes), 1);
    chk("held_d_glitch", 32'(offdone), 0);

    // Reset in the middle of RUN aborts without a done pulse
    @(posedge clk); #1;
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_d", 32'(d), 0);
    chk("abort_bout", 32'(bout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) npulse++;
    end
    chk("abort_no_activity", 32'(npulse), 0);
    chk("abort_d_held", 32'(d), 0);
    run_op(8'h09, 8'h09, 1'b0, r, lat, bcnt);
    chk("post_abort_d", 32'(r.d), 0);
    chk("post_abort_bout", 32'(r.bout), 0);
    chk("post_abort_latency", 32'(lat), W);

    // Randomized operands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(0, 1));
      m = model(ra, rb, rbin);
      run_op(ra, rb, rbin, r, lat, bcnt);
      chk($sformatf("rnd%0d_d(%0h-%0h-%0d)", i, ra, rb, rbin), 32'(r.d), 32'(m.d));
      chk($sformatf("rnd%0d_bout", i), 32'(r.bout), 32'(m.bout));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), W);
`ifdef SERIAL_SUB_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(r.ovf), 32'(m.ovf));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
